// File: rtl/bus_arb_pkg.sv
// Shared types for the four-requester round-robin bus arbiter.
package bus_arb_pkg;

  localparam int NREQ = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWN,
    ARB_GAP
  } arb_state_t;

  typedef logic [1:0] req_idx_t;

  function automatic logic [NREQ-1:0] idxToOneHot(input req_idx_t idx);
    logic [NREQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux4_1.sv
// Generic 4:1 data multiplexer.
module mux4_1 #(
  parameter int W = 16
) (
  input  logic [1:0]   i_sel,
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  input  logic [W-1:0] i_d2,
  input  logic [W-1:0] i_d3,
  output logic [W-1:0] o_y
);

  always_comb begin
    case (i_sel)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      default: o_y = i_d3;
    endcase
  end

endmodule

// File: rtl/rr_priority4.sv
// Round-robin pick: first requester set, scanning upward from one past the last owner.
module rr_priority4
  import bus_arb_pkg::*;
(
  input  logic [NREQ-1:0] i_req,
  input  req_idx_t        i_last,
  output logic            o_any,
  output req_idx_t        o_winner
);

  logic     w_found;
  req_idx_t w_cand;

  // The last owner itself is scanned last, so it only wins when nobody else asks.
  always_comb begin
    o_any    = |i_req;
    o_winner = '0;
    w_found  = 1'b0;
    w_cand   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_cand = i_last + req_idx_t'(i);
      if (!w_found && i_req[w_cand]) begin
        o_winner = w_cand;
        w_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin arbiter for the shared 4-input datapath bus, with a one-cycle dead gap between owners.
// Define BUS_ARB_TIMEOUT_EN to revoke a grant after MAX_HOLD owned cycles (pulsing Timeout).
module bus_arbiter4
  import bus_arb_pkg::*;
#(
  parameter int N = 16
`ifdef BUS_ARB_TIMEOUT_EN
  ,
  parameter int MAX_HOLD = 16
`endif
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [NREQ-1:0] Req,
  input  logic [NREQ-1:0] Done,
  input  logic [N-1:0]    A_In,
  input  logic [N-1:0]    B_In,
  input  logic [N-1:0]    C_In,
  input  logic [N-1:0]    D_In,
  output logic [NREQ-1:0] Gnt,
  output logic [1:0]      Sel,
  output logic            Bus_Valid,
  output logic [N-1:0]    Bus_Out,
  output logic            Timeout
);

  arb_state_t      r_state, w_nextState;
  logic [NREQ-1:0] r_gnt, w_nextGnt;
  req_idx_t        r_sel, w_nextSel;
  req_idx_t        r_last, w_nextLast;
  logic            r_timeout, w_nextTimeout;

  logic            w_any;
  req_idx_t        w_winner;
  logic            w_release;
  logic            w_expire;
  logic [N-1:0]    w_muxOut;

  rr_priority4 u_prio (
    .i_req   (Req),
    .i_last  (r_last),
    .o_any   (w_any),
    .o_winner(w_winner)
  );

  assign w_release = Done[r_sel] | ~Req[r_sel];

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  logic [CW-1:0] r_holdCnt;

  // Held at zero outside OWN so every grant starts counting from zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_holdCnt <= '0;
    end else if (r_state != ARB_OWN) begin
      r_holdCnt <= '0;
    end else begin
      r_holdCnt <= r_holdCnt + 1'b1;
    end
  end

  assign w_expire = (r_holdCnt == CW'(MAX_HOLD - 1));
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= ARB_IDLE;
      r_gnt     <= '0;
      r_sel     <= '0;
      r_last    <= req_idx_t'(NREQ - 1);
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_gnt     <= w_nextGnt;
      r_sel     <= w_nextSel;
      r_last    <= w_nextLast;
      r_timeout <= w_nextTimeout;
    end
  end

  // IDLE and GAP arbitrate identically; a normal release outranks a forced one.
  always_comb begin
    w_nextState   = r_state;
    w_nextGnt     = r_gnt;
    w_nextSel     = r_sel;
    w_nextLast    = r_last;
    w_nextTimeout = 1'b0;
    case (r_state)
      ARB_IDLE, ARB_GAP: begin
        if (w_any) begin
          w_nextState = ARB_OWN;
          w_nextGnt   = idxToOneHot(w_winner);
          w_nextSel   = w_winner;
        end else begin
          w_nextState = ARB_IDLE;
          w_nextGnt   = '0;
        end
      end
      ARB_OWN: begin
        if (w_release || w_expire) begin
          w_nextState   = ARB_GAP;
          w_nextGnt     = '0;
          w_nextLast    = r_sel;
          w_nextTimeout = ~w_release;
        end
      end
      default: begin
        w_nextState = ARB_IDLE;
        w_nextGnt   = '0;
      end
    endcase
  end

  mux4_1 #(.W(N)) u_busMux (
    .i_sel(r_sel),
    .i_d0 (A_In),
    .i_d1 (B_In),
    .i_d2 (C_In),
    .i_d3 (D_In),
    .o_y  (w_muxOut)
  );

  assign Gnt       = r_gnt;
  assign Sel       = r_sel;
  assign Bus_Valid = |r_gnt;
  assign Bus_Out   = Bus_Valid ? w_muxOut : '0;
  assign Timeout   = r_timeout;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Scoreboarded bench for bus_arbiter4: directed scenarios followed by random traffic.
module tb_bus_arbiter4;

  typedef struct packed {
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        valid;
    logic [15:0] bus;
    logic        tmo;
  } exp_t;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int MaxHold = 4;
`endif

  logic        Clk;
  logic        Reset;
  logic [3:0]  Req;
  logic [3:0]  Done;
  logic [15:0] A_In, B_In, C_In, D_In;
  logic [3:0]  Gnt;
  logic [1:0]  Sel;
  logic        Bus_Valid;
  logic [15:0] Bus_Out;
  logic        Timeout;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: current owner (-1 = nobody), last owner, select, owned-cycle index.
  int mOwner;
  int mLast;
  int mSel;
  int mHold;
  bit mTmo;

  bus_arbiter4 #(
    .N(16)
`ifdef BUS_ARB_TIMEOUT_EN
    ,
    .MAX_HOLD(MaxHold)
`endif
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Req      (Req),
    .Done     (Done),
    .A_In     (A_In),
    .B_In     (B_In),
    .C_In     (C_In),
    .D_In     (D_In),
    .Gnt      (Gnt),
    .Sel      (Sel),
    .Bus_Valid(Bus_Valid),
    .Bus_Out  (Bus_Out),
    .Timeout  (Timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [15:0] rnd16();
    return 16'($urandom);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, queue what the DUT must show this cycle, then step the model past the edge.
  task automatic applyStimulus(input logic rst, input logic [3:0] req, input logic [3:0] done,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] c, input logic [15:0] d);
    exp_t        e;
    logic [15:0] dat [4];
    bit          released;
    bit          expired;
    Reset = rst;
    Req   = req;
    Done  = done;
    A_In  = a;
    B_In  = b;
    C_In  = c;
    D_In  = d;
    dat[0] = a;
    dat[1] = b;
    dat[2] = c;
    dat[3] = d;
    e.gnt   = (mOwner >= 0) ? 4'(1 << mOwner) : 4'b0000;
    e.sel   = 2'(mSel);
    e.valid = (mOwner >= 0);
    e.bus   = (mOwner >= 0) ? dat[mSel] : 16'h0000;
    e.tmo   = mTmo;
    sbQ.push_back(e);

    if (rst) begin
      mOwner = -1;
      mLast  = 3;
      mSel   = 0;
      mHold  = 0;
      mTmo   = 1'b0;
    end else if (mOwner >= 0) begin
      released = done[mOwner] || !req[mOwner];
      expired  = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      expired = (mHold == MaxHold - 1);
`endif
      if (released || expired) begin
        mTmo   = !released;
        mLast  = mOwner;
        mOwner = -1;
      end else begin
        mHold++;
        mTmo = 1'b0;
      end
    end else begin
      mTmo = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        int cand;
        cand = (mLast + k) % 4;
        if (mOwner < 0 && req[cand]) begin
          mOwner = cand;
          mSel   = cand;
          mHold  = 0;
        end
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'b0000, 4'b0000, rnd16(), rnd16(), rnd16(), rnd16());
  endtask

  // Monitor: one expected record per cycle, compared away from the active edge.
  initial begin
    forever begin
      @(negedge Clk);
      if (sbQ.size() > 0) begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("Gnt", 32'(Gnt), 32'(e.gnt));
        checkOutput("Sel", 32'(Sel), 32'(e.sel));
        checkOutput("Bus_Valid", 32'(Bus_Valid), 32'(e.valid));
        checkOutput("Bus_Out", 32'(Bus_Out), 32'(e.bus));
        checkOutput("Timeout", 32'(Timeout), 32'(e.tmo));
      end
    end
  end

  initial begin
    logic [3:0] doneVec;
    Reset  = 1'b1;
    Req    = 4'b1111;
    Done   = 4'b0000;
    A_In   = '0;
    B_In   = '0;
    C_In   = '0;
    D_In   = '0;
    mOwner = -1;
    mLast  = 3;
    mSel   = 0;
    mHold  = 0;
    mTmo   = 1'b0;
    @(posedge Clk);
    #1;

    $display("[TB] reset with all requests held");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b1111, 4'b0000, rnd16(), rnd16(), rnd16(), rnd16());

    $display("[TB] round robin with Done after two owned cycles");
    for (int i = 0; i < 26; i++) begin
      doneVec = (mOwner >= 0 && mHold == 1) ? 4'(1 << mOwner) : 4'b0000;
      applyStimulus(1'b0, 4'b1111, doneVec, rnd16(), rnd16(), rnd16(), rnd16());
    end
    idleCycles(2);

    $display("[TB] single requester 2 data path");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'b0100, 4'b0000, rnd16(), rnd16(), 16'hBEEF, rnd16());
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 4'b0000, 4'b0000, rnd16(), rnd16(), 16'hBEEF, rnd16());

    $display("[TB] owner 1 releases by dropping Req, foreign Done ignored");
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 4'b0010, 4'b0000, rnd16(), rnd16(), rnd16(), rnd16());
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b1010, 4'b1000, rnd16(), rnd16(), rnd16(), rnd16());
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'b1000, 4'b0000, rnd16(), rnd16(), rnd16(), rnd16());
    idleCycles(3);

    $display("[TB] requester 1 stuck with requester 2 waiting");
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 4'b0010, 4'b0000, rnd16(), rnd16(), rnd16(), rnd16());
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 4'b0110, 4'b0000, rnd16(), rnd16(), rnd16(), rnd16());
    idleCycles(3);

    $display("[TB] reset while requester 3 owns the bus");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b1000, 4'b0000, rnd16(), rnd16(), rnd16(), rnd16());
    applyStimulus(1'b1, 4'b1000, 4'b0000, rnd16(), rnd16(), rnd16(), rnd16());
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'b1111, 4'b0000, rnd16(), rnd16(), rnd16(), rnd16());

    $display("[TB] random traffic");
    for (int i = 0; i < 500; i++) begin
      logic       rst;
      logic [3:0] req;
      logic [3:0] done;
      rst  = ($urandom_range(63) == 0);
      req  = ($urandom_range(3) == 0) ? 4'b0000 : 4'($urandom);
      done = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0000;
      applyStimulus(rst, req, done, rnd16(), rnd16(), rnd16(), rnd16());
    end

    @(negedge Clk);
    #1;
    checkOutput("sbDrain", 32'(sbQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
